// File: rtl/fifo_arb2_if.sv
// Bundle of producer, consumer and FIFO-side signals around fifo_arb2.
// slave is the arbiter's view; master is the surrounding system's view.
interface fifo_arb2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic                  m0_req;
  logic                  m1_req;
  logic [DATA_WIDTH-1:0] m0_data;
  logic [DATA_WIDTH-1:0] m1_data;
  logic                  m0_gnt;
  logic                  m1_gnt;
  logic                  s_rd_req;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  f_wr_en;
  logic                  f_rd_en;
  logic [DATA_WIDTH-1:0] f_d_in;
  logic [DATA_WIDTH-1:0] f_d_out;
  logic                  f_full;
  logic                  f_empty;
  logic                  f_wr_ack;
  logic                  f_wr_err;
  logic                  f_rd_ack;
  logic                  f_rd_err;
  logic [CNT_WIDTH-1:0]  f_data_count;
  logic                  err;
  logic [15:0]           wr_cnt;
  logic [15:0]           rd_cnt;

  modport slave (
    input  m0_req, m1_req, m0_data, m1_data, s_rd_req,
    input  f_d_out, f_full, f_empty, f_wr_ack, f_wr_err, f_rd_ack, f_rd_err, f_data_count,
    output m0_gnt, m1_gnt, s_data, s_valid, f_wr_en, f_rd_en, f_d_in, err, wr_cnt, rd_cnt
  );

  modport master (
    output m0_req, m1_req, m0_data, m1_data, s_rd_req,
    output f_d_out, f_full, f_empty, f_wr_ack, f_wr_err, f_rd_ack, f_rd_err, f_data_count,
    input  m0_gnt, m1_gnt, s_data, s_valid, f_wr_en, f_rd_en, f_d_in, err, wr_cnt, rd_cnt
  );
endinterface

// File: rtl/fifo_arb2.sv
// Round-robin two-producer write arbiter and single-consumer read sequencer
// in front of an 8-entry FIFO, with sticky error and traffic counters.
module fifo_arb2 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  fifo_arb2_if.slave     bus
);

  typedef enum logic {PRIO_M0, PRIO_M1} prio_t;

  prio_t                 prio;
  logic [CNT_WIDTH:0]    wr_level;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  gnt0;
  logic                  gnt1;
  logic [DATA_WIDTH-1:0] wr_word;

  // Occupancy counts the registered write still in flight; in-flight reads
  // are ignored so the full check can only err on the safe side.
  always_comb begin
    wr_level = {1'b0, bus.f_data_count} + {{CNT_WIDTH{1'b0}}, bus.f_wr_en};
    wr_ok    = (wr_level < (CNT_WIDTH+1)'(DEPTH)) && !bus.f_full;
    rd_ok    = ({1'b0, bus.f_data_count} > {{CNT_WIDTH{1'b0}}, bus.f_rd_en}) && !bus.f_empty;
    gnt0     = reset_n && wr_ok && bus.m0_req && (!bus.m1_req || prio == PRIO_M0);
    gnt1     = reset_n && wr_ok && bus.m1_req && (!bus.m0_req || prio == PRIO_M1);
    wr_word  = gnt0 ? bus.m0_data : bus.m1_data;
    bus.m0_gnt = gnt0;
    bus.m1_gnt = gnt1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio        <= PRIO_M0;
      bus.f_wr_en <= 1'b0;
      bus.f_d_in  <= '0;
      bus.f_rd_en <= 1'b0;
      bus.s_valid <= 1'b0;
      bus.s_data  <= '0;
      bus.wr_cnt  <= '0;
      bus.rd_cnt  <= '0;
      bus.err     <= 1'b0;
    end else begin
      bus.f_wr_en <= gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        bus.f_d_in <= wr_word;
        prio       <= gnt0 ? PRIO_M1 : PRIO_M0;
      end
      bus.f_rd_en <= bus.s_rd_req && rd_ok;
      bus.s_valid <= bus.f_rd_ack;
      if (bus.f_rd_ack) bus.s_data <= bus.f_d_out;
      if (bus.f_wr_ack) bus.wr_cnt <= bus.wr_cnt + 16'd1;
      if (bus.f_rd_ack) bus.rd_cnt <= bus.rd_cnt + 16'd1;
      if (bus.f_wr_err || bus.f_rd_err) bus.err <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_arb2.md
# fifo_arb2

Two-master write arbiter and single-consumer read scheduler placed in front of the 8-entry, 32-bit `fifo` block. It shares the FIFO write port between two producers with round-robin arbitration. It sequences FIFO reads on behalf of one consumer and never issues a write to a full FIFO or a read from an empty one. It also returns sticky error and traffic status to the system.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width
- `DEPTH`, 8, FIFO capacity in words
- `CNT_WIDTH`, 4, width of FIFO `data_count`; holds 0..DEPTH

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset (same net as the FIFO reset)
- `m0_req`, `m1_req`  in  1  producer write request, level; held until granted
- `m0_data`, `m1_data`  in  DATA_WIDTH  producer write word, stable while req is high
- `m0_gnt`, `m1_gnt`  out  1  combinational; word accepted at this rising edge
- `s_rd_req`  in  1  consumer read request, level
- `s_data`  out  DATA_WIDTH  registered read word
- `s_valid`  out  1  registered; one-cycle pulse per delivered word
- `f_wr_en`, `f_rd_en`  out  1  registered FIFO write/read enables
- `f_d_in`  out  DATA_WIDTH  registered FIFO write data
- `f_d_out`  in  DATA_WIDTH  FIFO read data
- `f_full`, `f_empty`, `f_wr_ack`, `f_wr_err`, `f_rd_ack`, `f_rd_err`  in  1  FIFO status
- `f_data_count`  in  CNT_WIDTH  FIFO occupancy
- `err`  out  1  sticky; set on any `f_wr_err` or `f_rd_err`
- `wr_cnt`, `rd_cnt`  out  16  words written to / read from the FIFO, wrap at 16'hFFFF→0

## Operation
- **FIFO contract.** The FIFO samples `f_wr_en`/`f_rd_en` at the rising edge. `f_data_count` reflects that edge in the following cycle. `f_rd_ack` and `f_d_out` are valid in the cycle after the edge that sampled `f_rd_en`.
- **Write eligibility.**
  - `wr_ok = (f_data_count + f_wr_en) < DEPTH`.
  - The pending registered write is counted; pending reads are ignored, which is conservative.
- **Arbitration.**
  - Round-robin pointer `prio` with values m0 and m1; reset value is m0.
  - When `wr_ok` holds:
    - Only one requester active: that requester is granted.
    - Both active: the `prio` master is granted.
  - After any grant, `prio` points to the other master.
  - At most one `mX_gnt` is high per cycle. Neither is high when `!wr_ok`.
- **Write issue.** At the edge where `mX_gnt` is high:
  - `f_wr_en` ← 1 and `f_d_in` ← `mX_data`.
  - Otherwise `f_wr_en` ← 0 and `f_d_in` holds its value.
- **Read eligibility.** `rd_ok = f_data_count > f_rd_en`.
- **Read issue.** At each edge, `f_rd_en` ← `s_rd_req & rd_ok`. This gives back-to-back reads while data remains.
- **Delivery.** At each edge:
  - `s_valid` ← `f_rd_ack`.
  - If `f_rd_ack` is high, `s_data` ← `f_d_out`; otherwise `s_data` holds.
- **Counters.**
  - `wr_cnt` increments at each edge where `f_wr_ack` is high.
  - `rd_cnt` increments at each edge where `f_rd_ack` is high.
- **Errors.** `err` ← 1 at any edge where `f_wr_err` or `f_rd_err` is high. It clears only on reset. In correct operation `err` stays 0.

## Timing
- **Reset.** While `reset_n` is low, immediately clear:
  - `f_wr_en`, `f_rd_en`, `f_d_in`, `s_data`, `s_valid`, `err`, `wr_cnt`, `rd_cnt`, all to 0;
  - `prio` to m0.
  - `mX_gnt` is forced to 0.
- **Reset mid-operation.** In-flight writes and reads are dropped with no partial delivery. The FIFO is cleared by the same reset.
- **Write latency.**
  - Grant at edge N.
  - `f_wr_en` is high during cycle N+1.
  - The word is stored at edge N+1.
  - `f_wr_ack` is seen and `wr_cnt` is updated at edge N+2.
  - Sustained throughput is 1 word/cycle. A single requester may be granted every cycle.
- **Read latency.**
  - `s_rd_req` is sampled at edge N.
  - `f_rd_en` is high during cycle N+1.
  - `f_rd_ack` is high during cycle N+2.
  - `s_valid` is high during cycle N+3.
  - Sustained throughput is 1 word/cycle.
- **Full boundary.**
  - Count 7 with a write pending: `wr_ok` = 0, and no grant until the count drops.
  - Count 8: no grant.
- **Empty boundary.** Count 1 with a read pending: `rd_ok` = 0, and no further `f_rd_en`.
- **Simultaneous events.**
  - A write grant and a read issue in the same cycle are independent.
  - During simultaneous traffic, `wr_ok`/`rd_ok` remain conservative and never over- or under-run the FIFO.
- **Request dropped.** If `s_rd_req` drops, reads already issued still deliver `s_valid` pulses.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-burst → all outputs 0 within the same cycle. After release, the first `m0_req` & `m1_req` grants m0.
- **Arbitration.** m0 and m1 request continuously, data 32'hA000_000n/32'hB000_000n, consumer idle → grants alternate m0, m1, … for exactly 8 words. Then both gnt stay 0, `f_full`=1, `err`=0, `wr_cnt`=8.
- **Drain.** From full, `s_rd_req`=1 → 8 `s_valid` pulses in the order A0,B0,A1,B1,…, with the first pulse 3 cycles after the request edge. Then `f_rd_en` stays 0, `rd_cnt`=8, `err`=0.
- **Concurrent traffic.** m0 only, 20 words, with `s_rd_req`=1 throughout → 20 words out in order. `f_data_count` stays ≤ 8 and ≥ 0, `err`=0.
- **Boundaries.** Fill to 7, then request m0 and m1 on the same edge → exactly one grant (m0) and a FIFO count of 8. With count 1, hold `s_rd_req` → exactly one `s_valid`.
- **Error path.** Force `f_wr_err`=1 for one cycle → `err`=1, held until `reset_n` is low.
